jtag_axi_dispatch: RTL and testbench
====================================

// Module: jtag_axi_dispatch
// PURPOSE
//  AXI-side sequencer that turns a JTAG-programmed request (addr, wdata, ctrl) into one single-beat AXI4
//  read or write on the system bus, then reports the response/read data back for capture in STATUS_AXI_REG.
//  Sits between the (already clock-crossed) data-register outputs and the AXI manager port; one txn in flight.
// PARAMETERS
//  ADDR_W     32    AXI address width (matches `AXI_ADDR_WIDTH)
//  DATA_W     32    AXI data width (matches `AXI_DATA_WIDTH); STRB_W = DATA_W/8
//  TXN_ID     0     constant AWID/ARID driven on every txn
//  TIMEOUT_W  12    width of watchdog counter; timeout after 2**TIMEOUT_W-1 cycles without completion
// PORTS
//  clk_axi     in   1        AXI clock; one clock, no other domain inside
//  rst_axi     in   1        reset, synchronous, active-high
//  req_valid   in   1        1-cycle pulse: dispatch new txn (synchronised axi_ctrl)
//  req_write   in   1        1=write, 0=read; sampled with req_valid
//  req_size    in   3        AxSIZE; sampled with req_valid
//  req_addr    in   ADDR_W   txn address; sampled with req_valid
//  req_wdata   in   DATA_W   write data; sampled with req_valid
//  req_wstrb   in   STRB_W   write strobes; sampled with req_valid
//  status_ack  in   1        1-cycle pulse: status consumed (synchronised axi_status_rd)
//  status      out  3        axi_jtag_status_t code (see BEHAVIOUR)
//  rdata       out  DATA_W   last read data; held until next read completes
//  busy        out  1        txn in flight
//  aw*/w*/b*   AXI4 write channels: awvalid/awready/awaddr/awid/awsize/awlen/awburst, wvalid/wready/wdata/wstrb/wlast,
//              bvalid/bready/bid/bresp
//  ar*/r*      AXI4 read channels: arvalid/arready/araddr/arid/arsize/arlen/arburst, rvalid/rready/rdata/rid/rresp/rlast
// BEHAVIOUR
//  Reset: FSM=IDLE, all valids/readies 0, status=ST_IDLE, rdata=0, busy=0, watchdog=0; applies mid-txn (bus not drained).
//  Fixed fields: awlen/arlen=0, awburst/arburst=INCR, wlast=1, awid/arid=TXN_ID.
//  status codes: ST_IDLE=0, ST_BUSY=1, ST_OKAY=2, ST_EXOKAY=3, ST_SLVERR=4, ST_DECERR=5, ST_TIMEOUT=6, ST_REJECT=7.
//  FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
//  IDLE: req_valid -> latch req_*, status=ST_BUSY, busy=1; write -> WR_ADDR_DATA (awvalid=wvalid=1 next cycle), read -> RD_ADDR.
//  WR_ADDR_DATA: aw and w issued concurrently; each valid drops the cycle after its own handshake; leave for WR_RESP
//   when both done (same cycle allowed). bready=1 only in WR_RESP.
//  WR_RESP: on bvalid&bready -> status from bresp, -> IDLE, busy=0.
//  RD_ADDR: arvalid=1 until arready -> RD_DATA (rready=1). RD_DATA: on rvalid -> rdata<=rdata_in, status from rresp, -> IDLE.
//  Valids never deasserted before handshake (AXI rule); payload stable while valid.
//  Watchdog: clears on leaving IDLE, +1 per cycle while busy; at max sets status=ST_TIMEOUT (saturates, no wrap).
//   FSM still completes handshakes; late response consumed, status stays ST_TIMEOUT, rdata not updated.
//  req_valid while busy: ignored for the bus, status:=ST_REJECT only after completion overwrites (reject sticky until ack).
//  status_ack: in IDLE -> status=ST_IDLE; while busy -> ignored. Ack and req_valid same cycle in IDLE: req wins (ST_BUSY).
//  Latency: req_valid -> awvalid/arvalid 1 cycle; response handshake -> status/busy update 1 cycle (registered outputs).
//  bid/rid mismatch vs TXN_ID -> treated as ST_SLVERR. rlast ignored (single beat).
// STRUCTURE
//  jtag_pkg: axi_jtag_status_t enum (codes above), dispatch_st_t FSM enum, DEFAULT_TIMEOUT_W.
//  amba_axi_pkg: resp encodings (OKAY/EXOKAY/SLVERR/DECERR), burst encoding INCR.
//  Single module; watchdog small enough to stay inline, no sub-module.
// TESTING
//  Write 0x1000/0xDEADBEEF, strb 0xF, awready&wready=1, bresp=OKAY after 2 cyc -> one aw+w beat, status=2, busy 0.
//  Write with wready delayed 5 cyc after awready -> awvalid drops after its hs, wvalid held stable, single B, status=2.
//  Read 0x2000, rdata=0xCAFEF00D, rresp=DECERR -> status=5, rdata=0xCAFEF00D; then status_ack -> status=0.
//  TIMEOUT_W=4, arready never -> status=6 at cycle 15; later arready+rvalid -> consumed, status stays 6, rdata unchanged.
//  req_valid during busy read -> no second ar, status=7 after completion; rst_axi mid-WR_RESP -> all outputs reset next cycle.

Source files
------------

// File: rtl/jtag_axi_dispatch_pkg.sv
// Shared types for the JTAG-to-AXI dispatcher: status codes, FSM states and AXI encodings.
package jtag_axi_dispatch_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_W = 12;
  localparam int unsigned AXI_ID_W          = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY    = 3'd1,
    ST_OKAY    = 3'd2,
    ST_EXOKAY  = 3'd3,
    ST_SLVERR  = 3'd4,
    ST_DECERR  = 3'd5,
    ST_TIMEOUT = 3'd6,
    ST_REJECT  = 3'd7
  } axi_jtag_status_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } dispatch_st_t;

  // A response carrying a foreign ID is not ours to trust, so it reports as a slave error.
  function automatic axi_jtag_status_t resp_to_status(input logic [1:0] resp, input logic id_ok);
    axi_jtag_status_t st;
    if (!id_ok) begin
      st = ST_SLVERR;
    end else begin
      case (resp)
        AXI_RESP_OKAY:   st = ST_OKAY;
        AXI_RESP_EXOKAY: st = ST_EXOKAY;
        AXI_RESP_SLVERR: st = ST_SLVERR;
        default:         st = ST_DECERR;
      endcase
    end
    return st;
  endfunction

endpackage

// File: rtl/jtag_axi_dispatch_if.sv
// Single-beat AXI4 manager bus used by the dispatcher (master) and the system-side subordinate (slave).
interface jtag_axi_dispatch_if
  import jtag_axi_dispatch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = AXI_ID_W
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [2:0]        awsize;
  logic [7:0]        awlen;
  logic [1:0]        awburst;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [2:0]        arsize;
  logic [7:0]        arlen;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awid, awsize, awlen, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arsize, arlen, arburst,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, awsize, awlen, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arsize, arlen, arburst,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rdata, rid, rresp, rlast
  );

endinterface

// File: rtl/jtag_axi_dispatch.sv
// Turns one JTAG-programmed request into a single-beat AXI4 read or write and reports the outcome.
// One transaction in flight; a watchdog flags a stuck bus without abandoning the handshakes.
module jtag_axi_dispatch
  import jtag_axi_dispatch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TXN_ID    = 0,
  parameter int unsigned TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic                clk_axi,
  input  logic                rst_axi,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [2:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                status_ack,
  output logic [2:0]          status,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  jtag_axi_dispatch_if.master axi
);

  localparam int unsigned          STRB_W   = DATA_W / 8;
  localparam logic [AXI_ID_W-1:0]  ID       = AXI_ID_W'(TXN_ID);
  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  dispatch_st_t         state_q,   state_d;
  axi_jtag_status_t     status_q,  status_d;
  logic [DATA_W-1:0]    rdata_q,   rdata_d;
  logic                 busy_q,    busy_d;
  logic [TIMEOUT_W-1:0] wdog_q,    wdog_d;
  logic                 timeout_q, timeout_d;
  logic                 reject_q,  reject_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q,  wvalid_d;
  logic [2:0]           size_q,    size_d;
  logic [ADDR_W-1:0]    addr_q,    addr_d;
  logic [DATA_W-1:0]    wdata_q,   wdata_d;
  logic [STRB_W-1:0]    wstrb_q,   wstrb_d;

  logic                 complete;
  axi_jtag_status_t     resp_st;

  always_ff @(posedge clk_axi) begin
    if (rst_axi) begin
      state_q   <= IDLE;
      status_q  <= ST_IDLE;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      reject_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      reject_q  <= reject_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    reject_d  = reject_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    complete  = 1'b0;
    resp_st   = ST_OKAY;

    case (state_q)
      IDLE: begin
        // A new request beats a simultaneous acknowledge.
        if (req_valid) begin
          size_d    = req_size;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          status_d  = ST_BUSY;
          busy_d    = 1'b1;
          wdog_d    = '0;
          timeout_d = 1'b0;
          reject_d  = 1'b0;
          if (req_write) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = RD_ADDR;
          end
        end else if (status_ack) begin
          status_d = ST_IDLE;
        end
      end
      WR_ADDR_DATA: begin
        if (axi.awready) awvalid_d = 1'b0;
        if (axi.wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          complete = 1'b1;
          resp_st  = resp_to_status(axi.bresp, axi.bid == ID);
        end
      end
      RD_ADDR: begin
        if (axi.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          complete = 1'b1;
          resp_st  = resp_to_status(axi.rresp, axi.rid == ID);
          if (!timeout_q) rdata_d = axi.rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    // A timed-out transaction still finishes its handshakes but keeps reporting the timeout;
    // a request seen while busy turns the final report into a reject.
    if (state_q != IDLE) begin
      if (req_valid) reject_d = 1'b1;
      if (complete) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (reject_q || req_valid) status_d = ST_REJECT;
        else if (!timeout_q)       status_d = resp_st;
      end else if (wdog_q != WDOG_MAX) begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_d == WDOG_MAX) begin
          timeout_d = 1'b1;
          status_d  = ST_TIMEOUT;
        end
      end
    end
  end

  assign status      = status_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awid    = ID;
  assign axi.awsize  = size_q;
  assign axi.awlen   = '0;
  assign axi.awburst = AXI_BURST_INCR;

  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;

  assign axi.bready  = (state_q == WR_RESP);

  assign axi.arvalid = (state_q == RD_ADDR);
  assign axi.araddr  = addr_q;
  assign axi.arid    = ID;
  assign axi.arsize  = size_q;
  assign axi.arlen   = '0;
  assign axi.arburst = AXI_BURST_INCR;

  assign axi.rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_jtag_axi_dispatch.sv
// Self-checking bench for jtag_axi_dispatch: directed scenarios plus randomized single-beat traffic.
module tb_jtag_axi_dispatch;
  import jtag_axi_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        status_ack = 1'b0;
  logic [2:0]  status;
  logic [31:0] rdata;
  logic        busy;

  int tests_run = 0;
  int failed    = 0;
  logic [31:0] exp_rdata = '0;

  // handshake monitor
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int stab_err = 0, fix_err = 0;
  logic [31:0] aw_addr_c, w_data_c, ar_addr_c, aw_prev, w_prev, ar_prev;
  logic [3:0]  w_strb_c;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0;

  jtag_axi_dispatch_if #(.ADDR_W(32), .DATA_W(32), .ID_W(AXI_ID_W)) axi ();

  jtag_axi_dispatch #(
    .ADDR_W(32), .DATA_W(32), .TXN_ID(0), .TIMEOUT_W(4)
  ) dut (
    .clk_axi(clk), .rst_axi(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .status_ack(status_ack), .status(status), .rdata(rdata), .busy(busy),
    .axi(axi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      if (aw_pend && (!axi.awvalid || axi.awaddr !== aw_prev)) stab_err++;
      if (w_pend && (!axi.wvalid || axi.wdata !== w_prev)) stab_err++;
      if (ar_pend && (!axi.arvalid || axi.araddr !== ar_prev)) stab_err++;
      if (axi.awvalid && axi.awready) begin
        aw_cnt++; aw_addr_c = axi.awaddr;
        if (axi.awlen !== 8'd0 || axi.awburst !== 2'b01 || axi.awid !== 4'd0) fix_err++;
      end
      if (axi.wvalid && axi.wready) begin
        w_cnt++; w_data_c = axi.wdata; w_strb_c = axi.wstrb;
        if (axi.wlast !== 1'b1) fix_err++;
      end
      if (axi.arvalid && axi.arready) begin
        ar_cnt++; ar_addr_c = axi.araddr;
        if (axi.arlen !== 8'd0 || axi.arburst !== 2'b01 || axi.arid !== 4'd0) fix_err++;
      end
      if (axi.bvalid && axi.bready) b_cnt++;
      if (axi.rvalid && axi.rready) r_cnt++;
      aw_pend = axi.awvalid && !axi.awready; aw_prev = axi.awaddr;
      w_pend  = axi.wvalid && !axi.wready;   w_prev  = axi.wdata;
      ar_pend = axi.arvalid && !axi.arready; ar_prev = axi.araddr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rid = '0; axi.rresp = '0; axi.rlast = 1;
  endtask

  // Reference outcome: reject dominates, a foreign ID is a slave error, else code = 2 + resp.
  function automatic logic [2:0] model_status(input logic [1:0] resp, input logic [3:0] id, input bit rej);
    if (rej) return 3'd7;
    if (id != 4'd0) return 3'd4;
    return 3'(2 + resp);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, input int b_d,
                          input logic [1:0] resp, input logic [3:0] id, input bit ack_mid);
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, ar0 = ar_cnt, st0 = stab_err;
    bit done = 0;
    logic [2:0] exp_st = model_status(resp, id, 0);
    req_valid = 1; req_write = 1; req_addr = a; req_wdata = d; req_wstrb = s; req_size = 3'd2;
    tick();
    req_valid = 0; status_ack = 0;
    tests_run++;
    if ({busy, status, axi.awvalid, axi.wvalid} !== {1'b1, 3'd1, 1'b1, 1'b1}) begin
      failed++;
      $display("FAIL wr_issue: busy/status/awv/wv=%b/%0d/%b/%b required 1/1/1/1", busy, status, axi.awvalid, axi.wvalid);
    end
    for (int c = 0; c < 30 && !done; c++) begin
      if (aw_cnt != aw0 && w_cnt == w0) begin
        tests_run++;
        if ({axi.awvalid, axi.wvalid} !== 2'b01) begin
          failed++;
          $display("FAIL wr_split: awv/wv=%b/%b required 0/1", axi.awvalid, axi.wvalid);
        end
      end
      axi.awready = (c >= aw_d);
      axi.wready  = (c >= w_d);
      axi.bvalid  = (aw_cnt == aw0 + 1 && w_cnt == w0 + 1 && c >= b_d && b_cnt == b0);
      axi.bresp   = resp;
      axi.bid     = id;
      status_ack  = ack_mid;
      tick();
      status_ack  = 0;
      if (b_cnt != b0) done = 1;
    end
    slave_idle();
    tests_run++;
    if (!done) begin
      failed++;
      $display("FAIL wr_timeout: no B handshake within 30 cycles, required one");
    end
    tests_run++;
    if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
      failed++;
      $display("FAIL wr_beats: aw/w/b/ar=%0d/%0d/%0d/%0d required 1/1/1/0", aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0);
    end
    tests_run++;
    if ({aw_addr_c, w_data_c, w_strb_c} !== {a, d, s}) begin
      failed++;
      $display("FAIL wr_payload: addr/data/strb=%h/%h/%h required %h/%h/%h", aw_addr_c, w_data_c, w_strb_c, a, d, s);
    end
    tests_run++;
    if ({busy, status, stab_err - st0} !== {1'b0, exp_st, 32'd0}) begin
      failed++;
      $display("FAIL wr_done: busy/status/stab=%b/%0d/%0d required 0/%0d/0", busy, status, stab_err - st0, exp_st);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int ar_d, input int r_d,
                         input logic [1:0] resp, input logic [3:0] id, input bit rej);
    int ar0 = ar_cnt, r0 = r_cnt, aw0 = aw_cnt, st0 = stab_err;
    bit done = 0;
    logic [2:0] exp_st = model_status(resp, id, rej);
    req_valid = 1; req_write = 0; req_addr = a; req_size = 3'd2;
    tick();
    req_valid = 0; status_ack = 0;
    tests_run++;
    if ({busy, status, axi.arvalid} !== {1'b1, 3'd1, 1'b1}) begin
      failed++;
      $display("FAIL rd_issue: busy/status/arv=%b/%0d/%b required 1/1/1", busy, status, axi.arvalid);
    end
    for (int c = 0; c < 30 && !done; c++) begin
      axi.arready = (c >= ar_d);
      axi.rvalid  = (ar_cnt == ar0 + 1 && c >= r_d && r_cnt == r0);
      axi.rdata   = d; axi.rresp = resp; axi.rid = id; axi.rlast = 1;
      req_valid   = rej && (c == 1);
      req_write   = 1; req_addr = ~a;
      tick();
      req_valid   = 0;
      if (r_cnt != r0) done = 1;
    end
    slave_idle();
    exp_rdata = d;
    tests_run++;
    if (!done) begin
      failed++;
      $display("FAIL rd_timeout: no R handshake within 30 cycles, required one");
    end
    tests_run++;
    if ({ar_cnt - ar0, r_cnt - r0, aw_cnt - aw0, ar_addr_c} !== {32'd1, 32'd1, 32'd0, a}) begin
      failed++;
      $display("FAIL rd_beats: ar/r/aw=%0d/%0d/%0d araddr=%h required 1/1/0 %h", ar_cnt - ar0, r_cnt - r0, aw_cnt - aw0, ar_addr_c, a);
    end
    tests_run++;
    if ({busy, status, rdata, stab_err - st0} !== {1'b0, exp_st, exp_rdata, 32'd0}) begin
      failed++;
      $display("FAIL rd_done: busy/status/rdata/stab=%b/%0d/%h/%0d required 0/%0d/%h/0", busy, status, rdata, stab_err - st0, exp_st, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    tests_run++;
    if ({busy, status, rdata, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== '0) begin
      failed++;
      $display("FAIL reset: busy/status/rdata=%b/%0d/%h valids/readies=%b%b%b%b%b required all 0", busy, status, rdata,
               axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_directed();
    do_write(32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 2, AXI_RESP_OKAY, 4'd0, 0);
    do_write(32'h1004, 32'h0BADF00D, 4'h3, 1, 6, 0, AXI_RESP_OKAY, 4'd0, 0);
    do_read(32'h2000, 32'hCAFEF00D, 0, 1, AXI_RESP_DECERR, 4'd0, 0);
    status_ack = 1;
    tick();
    status_ack = 0;
    tests_run++;
    if ({status, rdata} !== {3'd0, 32'hCAFEF00D}) begin
      failed++;
      $display("FAIL ack_clear: status/rdata=%0d/%h required 0/cafef00d", status, rdata);
    end
  endtask

  task automatic test_ack_and_req();
    // ack and request in the same idle cycle: the request wins
    status_ack = 1;
    do_read(32'h3000, 32'h12345678, 2, 3, AXI_RESP_EXOKAY, 4'd0, 0);
  endtask

  task automatic test_reject();
    do_read(32'h4000, 32'h55AA33CC, 2, 4, AXI_RESP_OKAY, 4'd0, 1);
    tick();
    tests_run++;
    if (status !== 3'd7) begin
      failed++;
      $display("FAIL reject_sticky: status=%0d required 7", status);
    end
    status_ack = 1;
    tick();
    status_ack = 0;
    tests_run++;
    if (status !== 3'd0) begin
      failed++;
      $display("FAIL reject_ack: status=%0d required 0", status);
    end
  endtask

  task automatic test_timeout();
    int ar0 = ar_cnt, r0 = r_cnt;
    bit done = 0;
    req_valid = 1; req_write = 0; req_addr = 32'h5000;
    tick();
    req_valid = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 14) begin
        tests_run++;
        if (status !== 3'd1) begin
          failed++;
          $display("FAIL to_early: status=%0d at cycle 14 required 1", status);
        end
      end
      if (k == 15 || k == 18) begin
        tests_run++;
        if ({busy, status, axi.arvalid} !== {1'b1, 3'd6, 1'b1}) begin
          failed++;
          $display("FAIL to_hit: busy/status/arv=%b/%0d/%b at cycle %0d required 1/6/1", busy, status, axi.arvalid, k);
        end
      end
    end
    for (int c = 0; c < 10 && !done; c++) begin
      axi.arready = 1;
      axi.rvalid  = (ar_cnt == ar0 + 1 && r_cnt == r0);
      axi.rdata   = 32'hFFFF0000; axi.rresp = AXI_RESP_OKAY; axi.rid = '0;
      tick();
      if (r_cnt != r0) done = 1;
    end
    slave_idle();
    tests_run++;
    if ({done, busy, status, rdata} !== {1'b1, 1'b0, 3'd6, exp_rdata}) begin
      failed++;
      $display("FAIL to_late: done/busy/status/rdata=%b/%b/%0d/%h required 1/0/6/%h", done, busy, status, rdata, exp_rdata);
    end
    status_ack = 1;
    tick();
    status_ack = 0;
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_write = 1; req_addr = 32'h6000; req_wdata = 32'h1; req_wstrb = 4'hF;
    tick();
    req_valid = 0;
    axi.awready = 1; axi.wready = 1;
    tick();
    slave_idle();
    tick();
    tests_run++;
    if ({busy, axi.bready} !== 2'b11) begin
      failed++;
      $display("FAIL rst_pre: busy/bready=%b/%b required 1/1", busy, axi.bready);
    end
    rst = 1;
    tick();
    exp_rdata = '0;
    tests_run++;
    if ({busy, status, rdata, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== '0) begin
      failed++;
      $display("FAIL rst_mid: busy/status/rdata=%b/%0d/%h bready=%b required 0/0/0/0", busy, status, rdata, axi.bready);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0] resp = 2'($urandom_range(0, 3));
      logic [3:0] id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), resp, id, 1'($urandom_range(0, 1)));
      else
        do_read($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), resp, id,
                ($urandom_range(0, 4) == 0));
    end
    tests_run++;
    if (fix_err !== 0) begin
      failed++;
      $display("FAIL fixed_fields: %0d bad len/burst/id/wlast beats, required 0", fix_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    slave_idle();
    test_reset();
    test_directed();
    test_ack_and_req();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
